id_ex_stage: RTL and testbench

- ID/EX pipeline register of the RV32I 5-stage core, with load-use hazard detection.
- Captures decoded operands and control from decode each cycle and presents them, registered, to the forwarding muxes and ALU in EX.
- Detects load-use hazards, stalls IF/ID and inserts a bubble.
- Honours branch flush from EX and global hold from MEM.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/id_ex_stage_hazard_detect.sv | 22 ++
 rtl/id_ex_stage.sv | 165 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Types and constants shared by the RV32I pipeline stages.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic [1:0] alu_sel;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the load sitting in EX and the instruction in ID.
module hazard_detect
  import rv32i_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              flush,
  output logic              luh,
  output logic              stall_if_id
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign luh = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  assign stall_if_id = luh & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
// Define ID_EX_WB_BYPASS_EN to forward the WB write port into the captured operands.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [1:0]        id_alu_sel,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              hold,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        ex_alu_sel,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d, id_ctrl;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;
  logic [XLEN-1:0]   op_a, op_b;
  logic              luh;

  hazard_detect u_hazard_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .luh         (luh),
    .stall_if_id (stall_if_id)
  );

  assign id_ctrl = '{alu_sel: id_alu_sel, alu_src: id_alu_src, reg_write: id_reg_write,
                     mem_read: id_mem_read, mem_write: id_mem_write,
                     mem_to_reg: id_mem_to_reg, branch: id_branch};

`ifdef ID_EX_WB_BYPASS_EN
  // Register bank writes and reads in the same cycle; take the value being written.
  always_comb begin
    op_a = id_rs1_data;
    op_b = id_rs2_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) op_a = wb_data;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) op_b = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_reg_write, wb_rd, wb_data};
  assign op_a = id_rs1_data;
  assign op_b = id_rs2_data;
`endif

  always_comb begin
    valid_d        = valid_q;
    ctrl_d         = ctrl_q;
    pc_d           = pc_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    rs1_data_d     = rs1_data_q;
    rs2_data_d     = rs2_data_q;
    imm_d          = imm_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (luh) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      rd_d    = '0;
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + CNT_W'(1);
    end else begin
      valid_d    = id_valid;
      ctrl_d     = id_valid ? id_ctrl : CTRL_NOP;
      pc_d       = id_pc;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = op_a;
      rs2_data_d = op_b;
      imm_d      = id_imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= 1'b0;
      ctrl_q         <= CTRL_NOP;
      pc_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      rd_q           <= '0;
      rs1_data_q     <= '0;
      rs2_data_q     <= '0;
      imm_q          <= '0;
      bubble_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      ctrl_q         <= ctrl_d;
      pc_q           <= pc_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      rd_q           <= rd_d;
      rs1_data_q     <= rs1_data_d;
      rs2_data_q     <= rs2_data_d;
      imm_q          <= imm_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_alu_sel    = ctrl_q.alu_sel;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, flow, load-use, x0, flush, hold, bypass.
module tb_id_ex_stage;
  import rv32i_pkg::*;

  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]        id_alu_sel;
  logic              id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic              flush, hold, wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [1:0]        ex_alu_sel;
  logic              ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic              stall_if_id;
  logic [CNT_W-1:0]  bubble_count;

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] bypassExpect;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .flush(flush), .hold(hold),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_sel(ex_alu_sel), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .stall_if_id(stall_if_id), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] rs1Data, input logic [31:0] rs2Data,
                               input logic [1:0] aluSel, input logic regWrite,
                               input logic memRead, input logic memWrite);
    id_valid      = valid;
    id_pc         = pc;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_rs1_data   = rs1Data;
    id_rs2_data   = rs2Data;
    id_imm        = pc + 32'h4;
    id_alu_sel    = aluSel;
    id_alu_src    = 1'b0;
    id_reg_write  = regWrite;
    id_mem_read   = memRead;
    id_mem_write  = memWrite;
    id_mem_to_reg = memRead;
    id_branch     = 1'b0;
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    hold = 1'b0;
    wb_reg_write = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("reset bubble_count", 32'(bubble_count), 32'h0);
    checkOutput("reset stall", 32'(stall_if_id), 32'h0);
    reset = 1'b1;
    stepCycle();

    // Normal flow
    applyStimulus(1'b1, 32'h100, 5'd3, 5'd4, 5'd6, 32'hAA, 32'h55, 2'b01, 1'b1, 1'b0, 1'b0);
    stepCycle();
    checkOutput("flow ex_valid", 32'(ex_valid), 32'h1);
    checkOutput("flow ex_rs1", 32'(ex_rs1), 32'd3);
    checkOutput("flow ex_rs1_data", ex_rs1_data, 32'hAA);
    checkOutput("flow ex_rs2_data", ex_rs2_data, 32'h55);
    checkOutput("flow ex_alu_sel", 32'(ex_alu_sel), 32'h1);
    checkOutput("flow ex_reg_write", 32'(ex_reg_write), 32'h1);
    checkOutput("flow ex_pc", ex_pc, 32'h100);
    checkOutput("flow ex_imm", ex_imm, 32'h104);
    checkOutput("flow ex_rd", 32'(ex_rd), 32'd6);

    // Invalid slot: controls forced low, data still captured
    applyStimulus(1'b0, 32'h200, 5'd1, 5'd2, 5'd9, 32'h11, 32'h22, 2'b10, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkOutput("invalid ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("invalid ex_reg_write", 32'(ex_reg_write), 32'h0);
    checkOutput("invalid ex_mem_write", 32'(ex_mem_write), 32'h0);
    checkOutput("invalid ex_pc", ex_pc, 32'h200);

    // Load-use: lw x5 then add using x5 as rs2
    applyStimulus(1'b1, 32'h300, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    stepCycle();
    checkOutput("lw ex_mem_read", 32'(ex_mem_read), 32'h1);
    applyStimulus(1'b1, 32'h304, 5'd2, 5'd5, 5'd8, 32'h2, 32'h5, 2'b00, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("luh stall", 32'(stall_if_id), 32'h1);
    stepCycle();
    checkOutput("bubble ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("bubble ex_rd", 32'(ex_rd), 32'h0);
    checkOutput("bubble ex_mem_read", 32'(ex_mem_read), 32'h0);
    checkOutput("bubble count", 32'(bubble_count), 32'd1);
    checkOutput("bubble stall clears", 32'(stall_if_id), 32'h0);
    stepCycle();
    checkOutput("add ex_valid", 32'(ex_valid), 32'h1);
    checkOutput("add ex_pc", ex_pc, 32'h304);
    checkOutput("add ex_rd", 32'(ex_rd), 32'd8);
    checkOutput("add ex_rs2", 32'(ex_rs2), 32'd5);
    checkOutput("add bubble count", 32'(bubble_count), 32'd1);

    // x0 never hazards
    applyStimulus(1'b1, 32'h400, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 32'h404, 5'd0, 5'd9, 5'd3, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("x0 ex_mem_read", 32'(ex_mem_read), 32'h1);
    checkOutput("x0 stall", 32'(stall_if_id), 32'h0);

    // Flush overrides load-use
    applyStimulus(1'b1, 32'h500, 5'd0, 5'd9, 5'd5, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 32'h504, 5'd5, 5'd1, 5'd7, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("flush stall", 32'(stall_if_id), 32'h0);
    stepCycle();
    flush = 1'b0;
    checkOutput("flush ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("flush ex_reg_write", 32'(ex_reg_write), 32'h0);
    checkOutput("flush bubble count", 32'(bubble_count), 32'd1);

    // Hold overrides load-use; stage frozen for three cycles
    applyStimulus(1'b1, 32'h600, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 32'h604, 5'd3, 5'd5, 5'd9, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      id_pc = 32'h700 + 32'(i);
      #1;
      checkOutput("hold ex_pc", ex_pc, 32'h600);
      checkOutput("hold ex_rd", 32'(ex_rd), 32'd5);
      checkOutput("hold stall", 32'(stall_if_id), 32'h1);
      checkOutput("hold bubble count", 32'(bubble_count), 32'd1);
    end
    hold = 1'b0;
    id_pc = 32'h604;
    stepCycle();
    checkOutput("post-hold bubble count", 32'(bubble_count), 32'd2);
    checkOutput("post-hold ex_valid", 32'(ex_valid), 32'h0);
    stepCycle();
    checkOutput("post-hold add ex_pc", ex_pc, 32'h604);
    checkOutput("post-hold add ex_alu_sel", 32'(ex_alu_sel), 32'h3);

    // WB bypass into operand B
    applyStimulus(1'b1, 32'h800, 5'd3, 5'd7, 5'd10, 32'h33, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    wb_reg_write = 1'b1;
    wb_rd = 5'd7;
    wb_data = 32'hDEAD_BEEF;
`ifdef ID_EX_WB_BYPASS_EN
    bypassExpect = 32'hDEAD_BEEF;
`else
    bypassExpect = 32'h0;
`endif
    stepCycle();
    wb_reg_write = 1'b0;
    checkOutput("bypass ex_rs2_data", ex_rs2_data, bypassExpect);
    checkOutput("bypass ex_rs1_data", ex_rs1_data, 32'h33);

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset ex_valid", 32'(ex_valid), 32'h0);
    checkOutput("async reset ex_reg_write", 32'(ex_reg_write), 32'h0);
    checkOutput("async reset ex_pc", ex_pc, 32'h0);
    checkOutput("async reset bubble count", 32'(bubble_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
